// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU controller.
//   OP_*     : 3-bit ALU op codes
//   state_t  : sequencer states
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_NOT = 3'd2;
  localparam logic [2:0] OP_SHL = 3'd3;
  localparam logic [2:0] OP_SHR = 3'd4;
  localparam logic [2:0] OP_AND = 3'd5;
  localparam logic [2:0] OP_OR  = 3'd6;
  localparam logic [2:0] OP_ONE = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU shared between requesters.
//   op : operation code (alu_pkg::OP_*)
//   a  : operand_1
//   b  : operand_2 (full width is the shift amount)
//   y  : result, modulo 2^32
module alu
  import alu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_ADD: y = a + b;
      OP_SUB: y = a - b;
      OP_NOT: y = ~a;
      // Shifting by the full 32-bit amount makes any count >= 32 produce 0.
      OP_SHL: y = a << b;
      OP_SHR: y = a >> b;
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_ONE: y = 32'd1;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first set request starting at ptr and
// wrapping modulo NREQ.
//   req       : request vector
//   ptr       : highest-priority index this cycle (< NREQ)
//   grant     : one-hot grant, zero when no request
//   grant_idx : encoded grant index
//   any       : at least one request present
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            any
);

  int idx;

  always_comb begin
    grant_idx = '0;
    idx       = 0;
    any       = |req;
    // Walk offsets from farthest to nearest so the lowest offset from ptr wins.
    for (int off = NREQ - 1; off >= 0; off--) begin
      idx = int'(ptr) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req[idx]) grant_idx = IDW'(idx);
    end
    grant = '0;
    if (any) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/alu_shared_ctrl.sv
// Shares one ALU between NREQ requesters with round-robin arbitration and a
// three-state sequencer (IDLE -> EXEC -> RESP).
//   clk, rst_n           : clock, synchronous active-low reset
//   req_valid/req_ready  : per-requester handshake (ready is one-hot or 0)
//   req_op/req_a/req_b   : flattened per-requester payload slices
//   rsp_valid/rsp_ready  : response handshake
//   rsp_id/rsp_result    : owner tag and registered result
//   rsp_zero             : rsp_result == 0
//   busy                 : sequencer not in IDLE
//
// state  | meaning
// S_IDLE | waiting for a request; grants and latches the winner
// S_EXEC | ALU evaluating the latched operands
// S_RESP | response held until the consumer takes it
module alu_shared_ctrl
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int W    = 32,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [3*NREQ-1:0] req_op,
  input  logic [W*NREQ-1:0] req_a,
  input  logic [W*NREQ-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_result,
  output logic              rsp_zero,
  output logic              busy
);

  state_t          state_q, state_d;
  logic [IDW-1:0]  rr_ptr;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_idx;
  logic            any_req;
  logic [2:0]      op_q;
  logic [W-1:0]    a_q, b_q, alu_y;
  logic [IDW-1:0]  id_q;
  logic [2:0]      sel_op;
  logic [W-1:0]    sel_a, sel_b;
  logic [IDW-1:0]  ptr_next;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any_req)
  );

  alu u_alu (
    .op (op_q),
    .a  (a_q),
    .b  (b_q),
    .y  (alu_y)
  );

  always_comb begin
    sel_op   = req_op[int'(grant_idx)*3 +: 3];
    sel_a    = req_a[int'(grant_idx)*W +: W];
    sel_b    = req_b[int'(grant_idx)*W +: W];
    ptr_next = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    busy      = 1'b1;
    case (state_q)
      S_IDLE: begin
        busy      = 1'b0;
        req_ready = grant;
        if (any_req) state_d = S_EXEC;
      end
      S_EXEC: state_d = S_RESP;
      S_RESP: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
    end else begin
      if (state_q == S_IDLE && any_req) begin
        op_q   <= sel_op;
        a_q    <= sel_a;
        b_q    <= sel_b;
        id_q   <= grant_idx;
        rr_ptr <= ptr_next;
      end
      if (state_q == S_EXEC) begin
        rsp_result <= alu_y;
        rsp_zero   <= (alu_y == '0);
        rsp_id     <= id_q;
        rsp_valid  <= 1'b1;
      end
      if (state_q == S_RESP && rsp_ready) rsp_valid <= 1'b0;
    end
  end

endmodule
